// File: rtl/lsu.sv
// RV32I load/store unit: forms the effective address, checks alignment/range/funct3,
// drives a single-port data memory and returns an extended load result one pulse later.
module lsu #(
  parameter int unsigned ADDR_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_we,
  output logic [2:0]  mem_wmode,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, CAPTURE, RESP} state_t;

  state_t      state, state_next;
  logic [31:0] ea;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [2:0]  funct3_q;
  logic        store_q;
  logic        fault_q;

  logic [1:0]  size;
  logic [2:0]  nbytes;
  logic [32:0] last_byte;
  logic        illegal, misaligned, out_of_range, fault;

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b100:  return {24'b0, d[7:0]};
      3'b101:  return {16'b0, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Fault checks look only at the registered request, so they are stable during WRITE/READ.
  always_comb begin
    size   = funct3_q[1:0];
    nbytes = 3'd4;
    case (size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    illegal = store_q ? (funct3_q >= 3'b011)
                      : (funct3_q == 3'b011 || funct3_q == 3'b110 || funct3_q == 3'b111);
    misaligned   = (size == 2'b01 && ea[0]) || (size == 2'b10 && ea[1:0] != 2'b00);
    // 33-bit sum so an access straddling the 2^32 wrap still lands out of range.
    last_byte    = {1'b0, ea} + 33'(nbytes) - 33'd1;
    out_of_range = last_byte >= 33'(ADDR_LIMIT);
    fault        = illegal || misaligned || out_of_range;
  end

  // NOTE: every output of this block gets a default first so no path leaves a latch behind.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_we     = 1'b0;
    mem_wmode  = 3'b000;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_store ? WRITE : READ;
      end
      WRITE: begin
        mem_we     = !fault;
        state_next = RESP;
      end
      READ:    state_next = fault ? RESP : CAPTURE;
      CAPTURE: state_next = RESP;
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (mem_we) begin
      case (size)
        2'b00:   mem_wmode = 3'b011;
        2'b01:   mem_wmode = 3'b100;
        default: mem_wmode = 3'b010;
      endcase
    end
  end

  // NOTE: all sequential state updates use non-blocking assignments so every register
  // samples values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ea       <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_valid) begin
            ea       <= req_base + req_offset;
            funct3_q <= req_funct3;
            store_q  <= req_store;
            if (req_store) wdata_q <= req_wdata;
          end
        end
        WRITE, READ: begin
          fault_q <= fault;
          rdata_q <= '0;
        end
        CAPTURE: rdata_q <= extend(funct3_q, mem_rdata);
        default: ;
      endcase
    end
  end

  assign mem_addr   = ea;
  assign mem_wdata  = wdata_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'd0;
  assign resp_fault = resp_valid && fault_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: expected responses are queued when a request is driven and
// compared, together with latency and memory-port activity, when the DUT responds.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base, req_offset, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [2:0]  mem_wmode;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;

  lsu #(.ADDR_LIMIT(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_we(mem_we), .mem_wmode(mem_wmode), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  wmode;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   we_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Byte-addressed data memory: LSB-aligned write data, read data registered one cycle later.
  logic [7:0] mem [1024];
  always @(posedge clk) begin
    logic [9:0] a;
    a = mem_addr[9:0];
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[10'h080] <= 8'h8F;
      mem[10'h081] <= 8'hF0;
      mem_rdata    <= '0;
    end else if (mem_we) begin
      mem[a] <= mem_wdata[7:0];
      if (mem_wmode == 3'b100 || mem_wmode == 3'b010) mem[a + 10'd1] <= mem_wdata[15:8];
      if (mem_wmode == 3'b010) begin
        mem[a + 10'd2] <= mem_wdata[23:16];
        mem[a + 10'd3] <= mem_wdata[31:24];
      end
    end else begin
      mem_rdata <= {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
    end
  end

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (mem_we) begin
      we_cnt++;
      if (sb.size() == 0) check("spurious_we", 32'd1, 32'd0);
      else begin
        check({sb[0].tag, "_addr"},  mem_addr,  sb[0].addr);
        check({sb[0].tag, "_wdata"}, mem_wdata, sb[0].wdata);
        check({sb[0].tag, "_wmode"}, 32'(mem_wmode), 32'(sb[0].wmode));
      end
    end
    if (resp_valid) begin
      if (sb.size() == 0) check("spurious_resp", 32'd1, 32'd0);
      else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_rdata"}, resp_rdata, mon_e.rdata);
        check({mon_e.tag, "_fault"}, 32'(resp_fault), 32'(mon_e.fault));
        check({mon_e.tag, "_lat"},   32'(cyc - acc_cyc), 32'(mon_e.lat));
        check({mon_e.tag, "_we"},    32'(we_cnt), 32'(mon_e.we));
      end
    end
    if (req_valid && req_ready && !rst) begin
      acc_cyc = cyc;
      we_cnt  = 0;
    end
  end

  function automatic exp_t mk_load(input string tag, input logic [31:0] rd);
    exp_t e;
    e.tag = tag; e.rdata = rd; e.fault = 1'b0; e.lat = 3; e.we = 0;
    e.addr = '0; e.wdata = '0; e.wmode = '0;
    return e;
  endfunction

  function automatic exp_t mk_store(input string tag, input logic [31:0] addr,
                                    input logic [31:0] wd, input logic [2:0] wmode);
    exp_t e;
    e.tag = tag; e.rdata = '0; e.fault = 1'b0; e.lat = 2; e.we = 1;
    e.addr = addr; e.wdata = wd; e.wmode = wmode;
    return e;
  endfunction

  function automatic exp_t mk_fault(input string tag);
    exp_t e;
    e.tag = tag; e.rdata = '0; e.fault = 1'b1; e.lat = 2; e.we = 0;
    e.addr = '0; e.wdata = '0; e.wmode = '0;
    return e;
  endfunction

  // Called one step after a rising edge with the DUT idle; returns the same way.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] wd, input exp_t e);
    int gap;
    req_valid = 1'b1; req_store = st; req_funct3 = f3;
    req_base = base; req_offset = off; req_wdata = wd;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_base = $urandom; req_offset = $urandom; req_wdata = $urandom;
    req_funct3 = 3'($urandom_range(7)); req_store = 1'($urandom_range(1));
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      gap++;
      if (req_ready) break;
    end
    check({e.tag, "_ready_gap"}, 32'(gap), 32'(e.lat));
    if (sb.size() != 0) begin
      check({e.tag, "_noresp"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_base = 32'h100; req_offset = 32'h4; req_wdata = 32'h5555AAAA;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",  32'(req_ready),  32'd1);
    check("rst_rvalid", 32'(resp_valid), 32'd0);
    check("rst_rdata",  resp_rdata,      32'd0);
    check("rst_rfault", 32'(resp_fault), 32'd0);
    check("rst_we",     32'(mem_we),     32'd0);
    check("rst_wmode",  32'(mem_wmode),  32'd0);
    check("rst_addr",   mem_addr,        32'd0);
    check("rst_wdata",  mem_wdata,       32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_we",    32'(mem_we),    32'd0);

    issue(1'b1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF, mk_store("sw_104", 32'h104, 32'hDEADBEEF, 3'b010));

    issue(1'b0, 3'b000, 32'h80, 32'h0, 32'h0, mk_load("lb_80",  32'hFFFFFF8F));
    issue(1'b0, 3'b100, 32'h80, 32'h0, 32'h0, mk_load("lbu_80", 32'h0000008F));
    issue(1'b0, 3'b001, 32'h80, 32'h0, 32'h0, mk_load("lh_80",  32'hFFFFF08F));
    issue(1'b0, 3'b101, 32'h80, 32'h0, 32'h0, mk_load("lhu_80", 32'h0000F08F));
    issue(1'b0, 3'b010, 32'h80, 32'h0, 32'h0, mk_load("lw_80",  32'h0000F08F));

    issue(1'b1, 3'b000, 32'h81, 32'h0, 32'h12345678, mk_store("sb_81", 32'h81, 32'h12345678, 3'b011));
    issue(1'b0, 3'b010, 32'h7C, 32'h4, 32'h0, mk_load("lw_80_after_sb", 32'h0000788F));
    issue(1'b0, 3'b010, 32'h104, 32'h0, 32'h0, mk_load("lw_104", 32'hDEADBEEF));

    issue(1'b1, 3'b001, 32'h400, 32'hFFFFFFFE, 32'hAAAA5555, mk_store("sh_3fe", 32'h3FE, 32'hAAAA5555, 3'b100));
    issue(1'b0, 3'b101, 32'h3FE, 32'h0, 32'h0, mk_load("lhu_3fe", 32'h00005555));
    issue(1'b0, 3'b010, 32'h3FC, 32'h0, 32'h0, mk_load("lw_3fc", 32'h55550000));

    issue(1'b0, 3'b010, 32'h100, 32'h2, 32'h0, mk_fault("f_lw_102"));
    issue(1'b0, 3'b001, 32'h3, 32'h0, 32'h0, mk_fault("f_lh_3"));
    issue(1'b1, 3'b010, 32'h3FE, 32'h0, 32'h11111111, mk_fault("f_sw_3fe"));
    issue(1'b0, 3'b010, 32'h3FC, 32'h4, 32'h0, mk_fault("f_lw_400"));
    issue(1'b0, 3'b011, 32'h80, 32'h0, 32'h0, mk_fault("f_ld_f3_011"));
    issue(1'b1, 3'b011, 32'h80, 32'h0, 32'h22222222, mk_fault("f_st_f3_011"));
    issue(1'b0, 3'b000, 32'hFFFFFFFF, 32'h0, 32'h0, mk_fault("f_lb_wrapped"));

    issue(1'b1, 3'b010, 32'h4, 32'h0, 32'hCAFEF00D, mk_store("sw_4", 32'h4, 32'hCAFEF00D, 3'b010));
    issue(1'b0, 3'b010, 32'hFFFFFFFC, 32'h8, 32'h0, mk_load("lw_wrap_4", 32'hCAFEF00D));

    // Reset during READ: the load must vanish without a response.
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
    req_base = 32'h80; req_offset = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready",  32'(req_ready),  32'd1);
    check("abort_rvalid", 32'(resp_valid), 32'd0);
    check("abort_we",     32'(mem_we),     32'd0);
    check("abort_addr",   mem_addr,        32'd0);
    repeat (4) @(posedge clk);
    #1;
    issue(1'b1, 3'b010, 32'h10, 32'h0, 32'h0BADF00D, mk_store("sw_after_abort", 32'h10, 32'h0BADF00D, 3'b010));
    issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h0, mk_load("lw_after_abort", 32'h0BADF00D));

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1);
  end

endmodule
